// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, word-addressed instruction memory with load port,
// and the IF/ID pipeline register feeding the controller.
module instr_fetch_unit #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] RESET_PC   = 32'h00000000
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Stall,
   input  logic                  i_PCSrc,
   input  logic [31:0]           i_BranchTarget,
   input  logic                  i_LoadEn,
   input  logic [ADDR_WIDTH-1:0] i_LoadAddr,
   input  logic [31:0]           i_LoadData,
   output logic [31:0]           o_PC,
   output logic [31:0]           o_Instruction,
   output logic [31:0]           o_PCPlus4,
   output logic                  o_Valid,
   output logic [31:0]           o_FetchCount
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           r_imem [0:DEPTH-1];
   logic [31:0]           r_pc;
   logic [31:0]           r_instr;
   logic [31:0]           r_pcplus4;
   logic                  r_valid;
   logic [31:0]           r_fetch_cnt;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [31:0]           w_rd_word;
   logic [31:0]           w_pc_next;

   // Byte offset and high bits are dropped, so fetch addresses alias modulo depth.
   assign w_rd_addr = r_pc[ADDR_WIDTH+1:2];
   assign w_rd_word = r_imem[w_rd_addr];
   assign w_pc_next = r_pc + 32'd4;

   // Load port is independent of reset so a program can be written while held in reset.
   always_ff @(posedge i_Clk) begin
      if (i_LoadEn)
         r_imem[i_LoadAddr] <= i_LoadData;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_pc        <= RESET_PC;
         r_instr     <= 32'h0;
         r_pcplus4   <= 32'h0;
         r_valid     <= 1'b0;
         r_fetch_cnt <= 32'h0;
      end else if (i_PCSrc) begin
         // Redirect squashes the slot fetched down the wrong path.
         r_pc      <= {i_BranchTarget[31:2], 2'b00};
         r_instr   <= 32'h0;
         r_pcplus4 <= 32'h0;
         r_valid   <= 1'b0;
      end else if (!i_Stall) begin
         r_pc        <= w_pc_next;
         r_instr     <= w_rd_word;
         r_pcplus4   <= w_pc_next;
         r_valid     <= 1'b1;
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   assign o_PC          = r_pc;
   assign o_Instruction = r_instr;
   assign o_PCPlus4     = r_pcplus4;
   assign o_Valid       = r_valid;
   assign o_FetchCount  = r_fetch_cnt;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage feeding the Controller and the register file.
- Holds the PC and a word-addressed instruction memory with a load port.
- Registers the fetched word into an IF/ID pipeline register, which drives Controller.Instruction.
- Consumes PCSrc and the branch target from the branch logic; redirects the PC and flushes the fetched slot.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- RESET_PC, 32'h00000000: byte address the PC takes on reset.

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Rst  input  1  synchronous reset, active-high
- Stall  input  1  hold PC and IF/ID contents
- PCSrc  input  1  branch taken; redirect PC to BranchTarget and flush IF/ID
- BranchTarget  input  32  byte address of redirect target
- LoadEn  input  1  write LoadData into instruction memory
- LoadAddr  input  ADDR_WIDTH  word address for load
- LoadData  input  32  instruction word to load
- PC  output  32  current fetch byte address
- Instruction  output  32  IF/ID instruction register (to Controller)
- PCPlus4  output  32  IF/ID copy of fetch PC + 4
- Valid  output  1  IF/ID slot holds a real fetched instruction
- FetchCount  output  32  number of instructions latched into IF/ID since reset

Behaviour:
- Reset (Rst=1 at edge): PC=RESET_PC, Instruction=0 (NOP), PCPlus4=0, Valid=0, FetchCount=0.
  - Memory contents are not cleared.
  - A LoadEn write in the same cycle still commits.
- Memory read:
  - Combinational read of imem[PC[ADDR_WIDTH+1:2]].
  - PC[1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo depth.
- Memory write:
  - Synchronous, on edge when LoadEn=1.
  - Same-cycle read of the same address returns the old word; the new word is visible from the next cycle.
- Latency: the word at PC appears on Instruction exactly one cycle after PC shows that address.
- Per-edge priority: Rst > PCSrc > Stall > normal.
- Normal (no Rst, PCSrc=0, Stall=0):
  - Instruction<=imem[PC], PCPlus4<=PC+4, Valid<=1, FetchCount<=FetchCount+1.
  - PC<=PC+4.
- Stall=1, PCSrc=0: PC, Instruction, PCPlus4, Valid and FetchCount all hold.
- PCSrc=1 (regardless of Stall):
  - PC<={BranchTarget[31:2],2'b00}; low bits are forced to zero.
  - Instruction<=0, PCPlus4<=0, Valid<=0; FetchCount holds.
  - Exactly one bubble per redirect.
- PCSrc held high for N cycles: PC reloads BranchTarget every cycle, and Valid stays 0 for all N cycles.
- Arithmetic:
  - PC+4 is 32-bit modular; 32'hFFFFFFFC advances to 32'h00000000.
  - FetchCount wraps from 32'hFFFFFFFF to 0.
- Reset mid-stall or mid-redirect: reset wins; all outputs take reset values on that edge.
- No combinational path from any input to any output except memory read to nothing; all outputs are registered.

Test Plan:
- Load imem[0..3]=32'h00000020, 32'h8C010000, 32'hAC010000, 32'h10010000, then Rst 1 cycle -> Valid=0, Instruction=0, PC=0. Next 4 edges -> Instruction 00000020, 8C010000, AC010000, 10010000; PC 4,8,C,10; PCPlus4 4,8,C,10; FetchCount=4.
- Stall=1 for 3 cycles after the 2nd fetch -> PC=8, Instruction=8C010000, FetchCount=2 held all 3 cycles. Release -> next Instruction=AC010000.
- PCSrc=1 with BranchTarget=32'h00000006 while at PC=C -> next edge PC=4, Valid=0, Instruction=0. Following edge -> Instruction=8C010000, Valid=1.
- PCSrc=1 and Stall=1 together, BranchTarget=0 -> PC=0, Valid=0 (redirect wins). Then Stall=0 -> Instruction=00000020.
- RESET_PC=32'hFFFFFFFC, ADDR_WIDTH=8, imem[255]=32'h12345678, imem[0]=32'h00000020 -> after reset, first fetch gives 12345678 with PCPlus4=0. Second fetch gives 00000020 with PC=4.
- LoadEn=1, LoadAddr=2, LoadData=32'hDEADBEEF in the same cycle PC=8 -> Instruction latches old AC010000. After redirect to 8 -> Instruction=DEADBEEF. Also, Rst asserted mid-run with Stall=1 -> PC=RESET_PC, FetchCount=0 on that edge.
